// File: rtl/state_dump_unit.sv
`default_nettype none
// ============================================================================
//  Module      : state_dump_unit
//  Description : Architectural-state readout engine for the mips core.
//                On a start request it freezes the core, walks the register
//                file and then the data memory, and streams every word out
//                on a valid/ready interface. Each beat carries its source
//                (out_kind) and its index (out_index).
//
//  Optional feature (compile-time macro DUMP_CHECKSUM_EN):
//                When defined, a running XOR of every dumped word is kept
//                and emitted as one extra beat (out_kind = 2'b10) after the
//                last memory word. When undefined, neither the checksum
//                state nor the accumulator exist.
//
//  Ports:
//    clk        in   1            system clock, rising edge
//    reset      in   1            asynchronous, active-high reset
//    start      in   1            one-cycle dump request, honoured in IDLE
//    stall      out  1            freezes core PC / write enables
//    rf_addr    out  RF_AW        register-file read address (= idx)
//    rf_data    in   DATA_W       combinational register-file read data
//    dm_addr    out  DM_AW        data-memory word read address (= idx)
//    dm_data    in   DATA_W       combinational data-memory read data
//    out_valid  out  1            output beat valid
//    out_ready  in   1            consumer accepts the beat
//    out_data   out  DATA_W       word being emitted
//    out_kind   out  2            00 register, 01 memory, 10 checksum
//    out_index  out  8            zero-extended source index
//    done       out  1            one-cycle pulse after the final transfer
//
//  Revision    : 1.0  initial release
// ============================================================================
module state_dump_unit #(
  parameter int DATA_W    = 32,
  parameter int REG_COUNT = 32,
  parameter int MEM_WORDS = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  output logic                         stall,
  output logic [$clog2(REG_COUNT)-1:0] rf_addr,
  input  logic [DATA_W-1:0]            rf_data,
  output logic [$clog2(MEM_WORDS)-1:0] dm_addr,
  input  logic [DATA_W-1:0]            dm_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic [1:0]                   out_kind,
  output logic [7:0]                   out_index,
  output logic                         done
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int RF_AW = $clog2(REG_COUNT);
  localparam int DM_AW = $clog2(MEM_WORDS);
  // One shared index walks both structures, so it must cover the wider one.
  localparam int IDX_W = (RF_AW > DM_AW) ? RF_AW : DM_AW;

  localparam logic [IDX_W-1:0] REG_LAST = IDX_W'(REG_COUNT - 1);
  localparam logic [IDX_W-1:0] MEM_LAST = IDX_W'(MEM_WORDS - 1);

  localparam logic [1:0] KIND_REG  = 2'b00;
  localparam logic [1:0] KIND_MEM  = 2'b01;
`ifdef DUMP_CHECKSUM_EN
  localparam logic [1:0] KIND_CSUM = 2'b10;
`endif

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REGS  = 3'd1;
  localparam logic [2:0] S_MEMS  = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
`ifdef DUMP_CHECKSUM_EN
  localparam logic [2:0] S_CSUM  = 3'd4;
  // After memory the checksum beat is queued before draining.
  localparam logic [2:0] S_AFTER_MEM = S_CSUM;
`else
  localparam logic [2:0] S_AFTER_MEM = S_DRAIN;
`endif

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [2:0]        r_state;
  logic [2:0]        w_state_next;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_idx_next;

  logic              w_slot_free;
  logic              w_xfer;
  logic              w_reg_last;
  logic              w_mem_last;

  logic              w_load;
  logic [1:0]        w_load_kind;
  logic [7:0]        w_load_index;
  logic [DATA_W-1:0] w_load_data;
  logic              w_finish;

`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] r_csum;
  logic              w_csum_clear;
  logic              w_csum_acc;
`endif

  // --------------------------------------------------------------------------
  // Handshake helpers and read addresses
  // --------------------------------------------------------------------------
  // The output register may take a new word when it is empty or when its
  // current word leaves this cycle.
  assign w_slot_free = !out_valid || out_ready;
  assign w_xfer      = out_valid && out_ready;
  assign w_reg_last  = (r_idx == REG_LAST);
  assign w_mem_last  = (r_idx == MEM_LAST);

  assign rf_addr = r_idx[RF_AW-1:0];
  assign dm_addr = r_idx[DM_AW-1:0];

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_REGS;
        end
      end
      S_REGS: begin
        if (w_slot_free && w_reg_last) begin
          w_state_next = S_MEMS;
        end
      end
      S_MEMS: begin
        if (w_slot_free && w_mem_last) begin
          w_state_next = S_AFTER_MEM;
        end
      end
`ifdef DUMP_CHECKSUM_EN
      S_CSUM: begin
        if (w_slot_free) begin
          w_state_next = S_DRAIN;
        end
      end
`endif
      S_DRAIN: begin
        // Only the final beat is left in the output register here.
        if (w_xfer) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output / control logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_load       = 1'b0;
    w_load_kind  = KIND_REG;
    w_load_index = 8'(r_idx);
    w_load_data  = '0;
    w_idx_next   = r_idx;
    w_finish     = 1'b0;
`ifdef DUMP_CHECKSUM_EN
    w_csum_clear = 1'b0;
    w_csum_acc   = 1'b0;
`endif
    // Stall follows the state directly so an asynchronous reset releases
    // the core in the same instant it abandons the dump.
    stall        = (r_state != S_IDLE);

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_idx_next   = '0;
`ifdef DUMP_CHECKSUM_EN
          w_csum_clear = 1'b1;
`endif
        end
      end
      S_REGS: begin
        if (w_slot_free) begin
          w_load      = 1'b1;
          w_load_kind = KIND_REG;
          w_load_data = rf_data;
          w_idx_next  = w_reg_last ? '0 : r_idx + 1'b1;
`ifdef DUMP_CHECKSUM_EN
          w_csum_acc  = 1'b1;
`endif
        end
      end
      S_MEMS: begin
        if (w_slot_free) begin
          w_load      = 1'b1;
          w_load_kind = KIND_MEM;
          w_load_data = dm_data;
          w_idx_next  = w_mem_last ? '0 : r_idx + 1'b1;
`ifdef DUMP_CHECKSUM_EN
          w_csum_acc  = 1'b1;
`endif
        end
      end
`ifdef DUMP_CHECKSUM_EN
      S_CSUM: begin
        if (w_slot_free) begin
          w_load       = 1'b1;
          w_load_kind  = KIND_CSUM;
          w_load_index = 8'h00;
          w_load_data  = r_csum;
        end
      end
`endif
      S_DRAIN: begin
        w_finish = w_xfer;
      end
      default: begin
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: index, output register and done pulse
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_kind  <= KIND_REG;
      out_index <= 8'h00;
      done      <= 1'b0;
    end else begin
      r_idx <= w_idx_next;
      done  <= w_finish;
      if (w_load) begin
        out_valid <= 1'b1;
        out_data  <= w_load_data;
        out_kind  <= w_load_kind;
        out_index <= w_load_index;
      end else if (w_xfer) begin
        // Reached only for the last beat: nothing new follows it.
        out_valid <= 1'b0;
      end
    end
  end

`ifdef DUMP_CHECKSUM_EN
  // --------------------------------------------------------------------------
  // Running XOR over every register and memory word that is loaded.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_csum <= '0;
    end else if (w_csum_clear) begin
      r_csum <= '0;
    end else if (w_csum_acc) begin
      r_csum <= r_csum ^ w_load_data;
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/state_dump_unit.md
Name: state_dump_unit

Overview:
- Walks the register file and the data memory of the mips core, then streams every word out on a valid/ready interface.
- Each beat is tagged with its source and index.
- The core is frozen (stall) for the whole dump.
- This is the on-chip producer side of architectural-state readout: the core emits its own register and memory image instead of having it probed hierarchically.

Parameters:
DATA_W, 32, width of register and memory words
REG_COUNT, 32, number of register-file entries dumped (indices 0..REG_COUNT-1)
MEM_WORDS, 32, number of data-memory words dumped (indices 0..MEM_WORDS-1)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle request to begin a dump; sampled only in IDLE
stall  output  1  freezes the core PC and write enables while a dump is in progress
rf_addr  output  $clog2(REG_COUNT)  register-file read address
rf_data  input  DATA_W  combinational register-file read data for rf_addr
dm_addr  output  $clog2(MEM_WORDS)  data-memory word read address
dm_data  input  DATA_W  combinational data-memory read data for dm_addr
out_valid  output  1  output beat valid
out_ready  input  1  consumer accepts the beat
out_data  output  DATA_W  word being emitted
out_kind  output  2  beat source: 00 = register, 01 = memory, 10 = checksum
out_index  output  8  register or memory index of the beat
done  output  1  one-cycle pulse when the final beat has been accepted

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high (reset).
- Reset values:
  - state = IDLE, idx = 0.
  - stall = 0, out_valid = 0, out_data = 0, out_kind = 00, out_index = 0, done = 0.
- Address outputs: rf_addr = idx and dm_addr = idx, both combinational from idx.
- Output register load rule: the output register loads when (!out_valid || out_ready), the "slot free" condition.
- Handshake:
  - A beat transfers on a cycle with out_valid && out_ready.
  - While out_valid = 1 and out_ready = 0, out_data, out_kind and out_index hold stable.
- States:
  - IDLE:
    - start = 1 moves to REGS with idx = 0.
    - stall goes high on the same edge, so it is 1 in the first REGS cycle.
  - REGS:
    - When the slot is free: load out_data = rf_data, out_kind = 00, out_index = idx, set out_valid = 1.
    - If idx = REG_COUNT-1: idx = 0 and go to MEMS. Otherwise idx++.
  - MEMS:
    - Same as REGS, using dm_data and out_kind = 01.
    - After loading idx = MEM_WORDS-1, go to DRAIN (or CSUM when the optional feature is enabled).
  - DRAIN:
    - No new loads.
    - When the last beat transfers: out_valid = 0, done = 1 for one cycle, stall = 0, return to IDLE.
- Throughput and latency:
  - With out_ready held at 1, one beat is produced per cycle.
  - First out_valid appears 2 cycles after start is sampled.
  - Total dump = REG_COUNT + MEM_WORDS beats; done is 1 cycle after the last transfer.
- Boundaries:
  - start while not IDLE is ignored.
  - out_ready may toggle arbitrarily: no beat is lost or duplicated, and index order is strictly ascending (registers first, then memory).
  - Reset asserted mid-dump immediately returns to the reset values. The dump is abandoned, no done pulse is produced, and stall releases.
  - out_index is zero-extended to 8 bits.
- Timing: rf_data and dm_data are sampled in the same cycle as the address. No read latency is assumed.

Optional Feature:
- Macro: DUMP_CHECKSUM_EN.
- Defined:
  - A running XOR accumulator over every loaded register and memory word is cleared on start.
  - After the last memory word, state CSUM loads one extra beat when the slot is free: out_kind = 10, out_index = 0, out_data = accumulator.
  - The unit then goes to DRAIN. Total beats = REG_COUNT + MEM_WORDS + 1.
- Undefined: the CSUM state and the accumulator are absent, and out_kind 10 never occurs.

Test Plan:
- Register pass: reg[i] = i*3, dmem[i] = 32'hA000_0000+i, out_ready = 1, pulse start -> 64 beats, one per cycle.
  - Registers come first: kind 00, index 0..31, data 0,3,...,93.
  - Memory follows: kind 01, data A0000000..A000001F.
  - done occurs exactly once, 1 cycle after beat 64.
  - stall is high from the cycle after start until done.
- Backpressure: out_ready toggles 1,0,0,1 repeatedly -> identical 64-beat sequence; out_data is stable in every cycle with out_valid && !out_ready.
- Ignored restart: pulse start again at beat 10 -> no restart; still exactly 64 beats and one done.
- Reset mid-dump: assert reset at beat 40 -> out_valid = 0 and stall = 0 immediately, no done. A new start yields a full dump beginning at register 0.
- DUMP_CHECKSUM_EN: regs all 0, dmem[5] = 32'h1234_5678, dmem[9] = 32'h0000_00FF, others 0 -> 65th beat has kind 10 and data 32'h1234_5687. done follows beat 65.
- Idle stability: no start for 100 cycles -> out_valid = 0, stall = 0, done = 0 throughout.
